// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM duty ramp controller.
package pwm_pkg;

  localparam int unsigned PWM_DUTY_W = 10;
  localparam int unsigned PWM_PERIOD = 2 ** PWM_DUTY_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } pwm_ramp_state_t;

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter; period_end flags the last count before wrap.
module pwm_period_cnt
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W = PWM_DUTY_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DUTY_W-1:0] cnt,
  output logic              period_end
);

  logic [DUTY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + DUTY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt        = cnt_q;
  assign period_end = &cnt_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Accepts duty commands and slews the PWM duty toward the target by a fixed
// step once per period, updating only on the period wrap edge.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned       DUTY_W    = PWM_DUTY_W,
  parameter int unsigned       STEP_W    = 4,
  parameter logic [DUTY_W-1:0] INIT_DUTY = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              period_end,
  output logic              busy,
  output logic              done
);

  pwm_ramp_state_t   state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [STEP_W-1:0] stp_q, stp_d;
  logic [DUTY_W-1:0] cnt;
  logic              at_wrap;
  logic [DUTY_W:0]   stp_ext, sum, diff;

  pwm_period_cnt #(.DUTY_W(DUTY_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .cnt        (cnt),
    .period_end (period_end)
  );

  assign at_wrap = (cnt == '1);

  // One extra bit catches both overflow past all-ones and borrow below zero.
  assign stp_ext = {{(DUTY_W + 1 - STEP_W){1'b0}}, stp_q};
  assign sum     = {1'b0, duty_q} + stp_ext;
  assign diff    = {1'b0, duty_q} - stp_ext;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    stp_d   = stp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d   = cmd_target;
          stp_d   = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (at_wrap) begin
          if (duty_q < tgt_q) begin
            duty_d = (sum > {1'b0, tgt_q}) ? tgt_q : sum[DUTY_W-1:0];
          end else if (duty_q > tgt_q) begin
            duty_d = (diff[DUTY_W] || (diff[DUTY_W-1:0] < tgt_q)) ? tgt_q
                                                                  : diff[DUTY_W-1:0];
          end
          if (duty_d == tgt_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= INIT_DUTY;
      tgt_q   <= '0;
      stp_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      stp_q   <= stp_d;
    end
  end

  assign duty      = duty_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench: stimulus queues expected duty changes and done pulses,
// a monitor pops and compares each event the DUT presents.
module tb_pwm_ramp_ctrl;

  localparam int DW = 10;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, abort, period_end, busy, done;
  logic [DW-1:0] cmd_target, duty;
  logic [SW-1:0] cmd_step;

  logic          s_cmd_valid, s_cmd_ready, s_abort, s_period_end, s_busy, s_done;
  logic [DW-1:0] s_cmd_target, s_duty;
  logic [SW-1:0] s_cmd_step;

  always #5 clk = ~clk;

  pwm_ramp_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .abort      (abort),
    .duty       (duty),
    .period_end (period_end),
    .busy       (busy),
    .done       (done)
  );

  pwm_ramp_ctrl #(.INIT_DUTY(10'd1020)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (s_cmd_valid),
    .cmd_ready  (s_cmd_ready),
    .cmd_target (s_cmd_target),
    .cmd_step   (s_cmd_step),
    .abort      (s_abort),
    .duty       (s_duty),
    .period_end (s_period_end),
    .busy       (s_busy),
    .done       (s_done)
  );

  typedef struct packed {
    logic          is_done;
    logic [DW-1:0] duty;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          mon_en   = 1'b0;
  logic [DW-1:0] prev_duty = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_duty(input int v);
    exp_q.push_back('{is_done: 1'b0, duty: DW'(v)});
  endtask

  task automatic push_done(input int v);
    exp_q.push_back('{is_done: 1'b1, duty: DW'(v)});
  endtask

  task automatic compare_event(input logic kind, input logic [DW-1:0] val);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s duty=%0d expected no event",
               kind ? "done" : "duty_change", val);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != kind || e.duty != val) begin
        n_fail++;
        $display("FAIL scoreboard_event: got %s duty=%0d expected %s duty=%0d",
                 kind ? "done" : "duty_change", val,
                 e.is_done ? "done" : "duty_change", e.duty);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (duty !== prev_duty) begin
        compare_event(1'b0, duty);
        prev_duty = duty;
      end
      if (done === 1'b1) compare_event(1'b1, duty);
    end
  end

  task automatic send_cmd(input logic [DW-1:0] t, input logic [SW-1:0] s);
    check("cmd_ready_before_send", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_target = t;
    cmd_step   = s;
    @(negedge clk);
    cmd_valid  = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("cmd_ready_after_accept", int'(cmd_ready), 0);
  endtask

  task automatic wait_period_end();
    int n = 0;
    while (period_end !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("period_end_seen", int'(period_end), 1);
  endtask

  task automatic wait_wraps(input int n);
    for (int i = 0; i < n; i++) begin
      wait_period_end();
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", int'(done), 1);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("cmd_ready_after_done", int'(cmd_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic sat_bad;
    cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0; abort = 1'b0;
    s_cmd_valid = 1'b0; s_cmd_target = '0; s_cmd_step = '0; s_abort = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Reset values and first period_end latency
    @(negedge clk);
    n = 1;
    check("reset_duty", int'(duty), 0);
    check("reset_cmd_ready", int'(cmd_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_period_end", int'(period_end), 0);
    while (period_end !== 1'b1 && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("first_period_end_latency", n, 1023);
    @(negedge clk);

    // Up ramp 0 -> 10 step 4
    push_duty(4); push_duty(8); push_duty(10); push_done(10);
    send_cmd(10'd10, 4'd4);
    wait_done(4 * 1024 + 16);

    // Down ramp 10 -> 0 step 3, then step 0 treated as 1
    push_duty(7); push_duty(4); push_duty(1); push_duty(0); push_done(0);
    send_cmd(10'd0, 4'd3);
    wait_done(5 * 1024 + 16);
    push_duty(1); push_duty(2); push_done(2);
    send_cmd(10'd2, 4'd0);
    wait_done(3 * 1024 + 16);
    push_duty(0); push_done(0);
    send_cmd(10'd0, 4'd2);
    wait_done(2 * 1024 + 16);

    // Abort mid-ramp after two updates
    push_duty(5); push_duty(10);
    send_cmd(10'd100, 4'd5);
    wait_wraps(2);
    check("duty_before_abort", int'(duty), 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_cmd_ready", int'(cmd_ready), 1);
    check("abort_duty_held", int'(duty), 10);
    wait_wraps(1);
    check("abort_duty_after_wrap", int'(duty), 10);

    // Abort coincident with period_end
    push_duty(15);
    send_cmd(10'd100, 4'd5);
    wait_wraps(1);
    check("duty_before_pe_abort", int'(duty), 15);
    wait_period_end();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("pe_abort_duty_held", int'(duty), 15);
    check("pe_abort_busy", int'(busy), 0);
    check("pe_abort_cmd_ready", int'(cmd_ready), 1);
    wait_wraps(1);
    check("pe_abort_duty_after_wrap", int'(duty), 15);

    // Commands during RAMP are ignored
    push_duty(20); push_duty(25); push_duty(30); push_done(30);
    send_cmd(10'd30, 4'd5);
    cmd_valid = 1'b1; cmd_target = 10'd500; cmd_step = 4'd15;
    repeat (1500) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done(3 * 1024 + 16);
    check("busy_protect_final_duty", int'(duty), 30);

    // Acceptance on the period_end cycle waits for the following wrap
    push_duty(40); push_done(40);
    wait_period_end();
    send_cmd(10'd40, 4'd10);
    check("edge_accept_duty_held", int'(duty), 30);
    wait_done(2 * 1024 + 16);
    check("edge_accept_final_duty", int'(duty), 40);

    // Saturation at the top of range on the INIT_DUTY=1020 instance
    check("sat_init_duty", int'(s_duty), 1020);
    check("sat_cmd_ready", int'(s_cmd_ready), 1);
    s_cmd_valid = 1'b1; s_cmd_target = 10'd1023; s_cmd_step = 4'd15;
    @(negedge clk);
    s_cmd_valid = 1'b0;
    sat_bad = 1'b0;
    n = 0;
    while (s_done !== 1'b1 && n < 2100) begin
      @(negedge clk);
      if (s_duty != 10'd1020 && s_duty != 10'd1023) sat_bad = 1'b1;
      n++;
    end
    check("sat_done_seen", int'(s_done), 1);
    check("sat_final_duty", int'(s_duty), 1023);
    check("sat_no_wrap", int'(sat_bad), 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
